cla_nibble_sequencer: RTL and testbench

Multi-word adder front end for the team's 4-bit `carry_look_ahead_adder`. It accepts WIDTH-bit operands over a valid/ready handshake and feeds them to a single CLA instance one nibble per cycle, least significant nibble first, registering the carry between nibbles. It returns the full WIDTH-bit sum and carry-out over a second valid/ready handshake. It sits between the operand source and any consumer of wide sums, giving wide addition without replicating the CLA.

---
 rtl/cla_pkg.sv | 12 +
 rtl/cla_nibble_sequencer_if.sv | 26 ++
 rtl/carry_look_ahead_adder.sv | 27 ++
 rtl/cla_nibble_sequencer.sv | 103 ++++++++++
 tb/tb_cla_nibble_sequencer.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/cla_pkg.sv
// Shared constants and FSM encoding for the nibble-serial CLA sequencer.
package cla_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla_nibble_sequencer_if.sv
// Operand request and result handshakes of the nibble-serial wide adder.
interface cla_nibble_sequencer_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );

endinterface

// File: rtl/carry_look_ahead_adder.sv
// 4-bit carry look-ahead adder: all internal carries from generate/propagate terms.
module carry_look_ahead_adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       Cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = A & B;
  assign p = A ^ B;

  assign c[0] = Cin;
  assign c[1] = g[0] | (p[0] & Cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & Cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & Cin);

  assign S    = p ^ c[3:0];
  assign Cout = c[4];

endmodule

// File: rtl/cla_nibble_sequencer.sv
// WIDTH-bit adder built from one 4-bit CLA stepped LSB nibble first, with a registered carry.
module cla_nibble_sequencer
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  cla_nibble_sequencer_if.slave  bus
);

  localparam int NIB    = WIDTH / NIBBLE_W;
  localparam int IDX_W  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int BASE_W = $clog2(WIDTH);

  generate
    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
      $error("cla_nibble_sequencer: WIDTH must be a positive multiple of 4");
    end
  endgenerate

  state_t              state;
  state_t              state_nxt;
  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;
  logic                c_q;
  logic [IDX_W-1:0]    idx;
  logic [WIDTH-1:0]    sum_q;
  logic                cout_q;
  logic                in_ready;
  logic                out_valid;
  logic                accept;
  logic                last;
  logic [BASE_W-1:0]   base;
  logic [NIBBLE_W-1:0] nib_sum;
  logic                nib_cout;

  assign accept = bus.in_valid & in_ready;
  assign last   = (idx == IDX_W'(NIB - 1));
  // Bit offset of the current nibble; truncation only matters for WIDTH==4 where idx is 0.
  assign base   = BASE_W'({idx, 2'b00});

  carry_look_ahead_adder u_cla (a_q[base +: NIBBLE_W], b_q[base +: NIBBLE_W], c_q, nib_sum, nib_cout);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = bus.in_valid ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready = 1'b1;
      DONE: begin
        in_ready  = bus.out_ready;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Operand copies carry no reset: they are only read after a handshake loads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= bus.a;
      b_q <= bus.b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q    <= 1'b0;
      idx    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (accept) begin
      c_q <= bus.cin;
      idx <= '0;
    end else if (state == RUN) begin
      sum_q[base +: NIBBLE_W] <= nib_sum;
      c_q                     <= nib_cout;
      idx                     <= last ? '0 : idx + IDX_W'(1);
      if (last) cout_q <= nib_cout;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Directed plus randomized bench for the 16-bit nibble-serial CLA sequencer.
module tb_cla_nibble_sequencer;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  cla_nibble_sequencer_if #(.WIDTH(WIDTH)) bus ();

  cla_nibble_sequencer #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide addition, bit WIDTH is the carry out.
  function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic c);
    return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
  endfunction

  // Called 1ns after an edge; returns 1ns after the handshake edge.
  task automatic issue(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v, input logic tc,
                       input logic release_prev);
    bus.a         = ta;
    bus.b         = tb_v;
    bus.cin       = tc;
    bus.in_valid  = 1'b1;
    bus.out_ready = release_prev;
    #1;
    check("in_ready_at_issue", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = WIDTH'($urandom);
    bus.b         = WIDTH'($urandom);
    bus.cin       = 1'($urandom);
  endtask

  task automatic expect_result(input string tag, input logic [WIDTH:0] exp);
    check({tag, "_busy"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_in_ready_busy"}, 32'(bus.in_ready), 32'd0);
    for (int i = 1; i <= NIB; i++) begin
      @(posedge clk); #1;
      check({tag, "_out_valid_latency"}, 32'(bus.out_valid), (i == NIB) ? 32'd1 : 32'd0);
    end
    check({tag, "_sum"}, 32'(bus.sum), 32'(exp[WIDTH-1:0]));
    check({tag, "_cout"}, 32'(bus.cout), 32'(exp[WIDTH]));
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("out_valid_after_release", 32'(bus.out_valid), 32'd0);
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic hold_check(input int cycles, input logic [WIDTH:0] exp);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
      check("hold_sum", 32'(bus.sum), 32'(exp[WIDTH-1:0]));
      check("hold_cout", 32'(bus.cout), 32'(exp[WIDTH]));
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rc;
    logic [WIDTH:0]   exp;
    logic             pending;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;

    // Asynchronous reset between edges, observed before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    issue(16'h0001, 16'h0000, 1'b0, 1'b0);
    expect_result("simple", 17'h00001);
    release_result();

    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    expect_result("ripple", 17'h10000);
    release_result();

    issue(16'h0B05, 16'h0603, 1'b1, 1'b0);
    expect_result("mixed1", 17'h01109);
    release_result();

    issue(16'h8000, 16'h8000, 1'b1, 1'b0);
    expect_result("mixed2", 17'h10001);

    // Backpressure, then back-to-back acceptance on the releasing edge.
    hold_check(5, 17'h10001);
    issue(16'h1234, 16'h4321, 1'b0, 1'b1);
    expect_result("b2b", 17'h05555);

    // Asynchronous reset while a result is held in DONE.
    #2 rst = 1'b1;
    #1;
    check("rst_done_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_done_sum", 32'(bus.sum), 32'd0);
    check("rst_done_cout", 32'(bus.cout), 32'd0);
    check("rst_done_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset pulse during the second RUN cycle aborts the request.
    issue(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    #2 rst = 1'b0;
    for (int i = 0; i < 2 * NIB; i++) begin
      @(posedge clk); #1;
      check("abort_no_out_valid", 32'(bus.out_valid), 32'd0);
    end
    check("abort_in_ready_idle", 32'(bus.in_ready), 32'd1);
    issue(16'h7FFF, 16'h0001, 1'b1, 1'b0);
    expect_result("after_abort", 17'h08001);
    release_result();

    // Randomized operands, random hold times, random back-to-back chaining.
    pending = 1'b0;
    for (int it = 0; it < 30; it++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
      if (it % 5 == 0) ra = '1;
      if (it % 7 == 0) rb = ~ra;
      exp = ref_add(ra, rb, rc);
      if (pending && ($urandom_range(0, 1) == 1)) begin
        issue(ra, rb, rc, 1'b1);
      end else begin
        if (pending) release_result();
        issue(ra, rb, rc, 1'b0);
      end
      expect_result("rand", exp);
      hold_check($urandom_range(0, 2), exp);
      pending = 1'b1;
    end
    release_result();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
